// File: rtl/awgn_pkg.sv
// Shared definitions for the AWGN seed-loading path: LCG constants,
// Tausworthe seed floor, loader states and the seed-fixing helper.
package awgn_pkg;

  localparam int SEED_W    = 32;
  localparam int NUM_SEEDS = 6;

  // L'Ecuyer multiplier used to spread one master seed into six.
  localparam logic [SEED_W-1:0] LCG_MULT = 32'd69069;

  // Any seed below this floor is lifted so every Tausworthe component
  // (which needs s > 1, s > 7 and s > 15 respectively) gets a legal value.
  localparam logic [SEED_W-1:0] TAUS_SEED_MIN = 32'd16;

  typedef logic [SEED_W-1:0] seed_t;

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    LOAD,
    WARM,
    RUN
  } loader_state_t;

  // Lift a too-small seed above the Tausworthe minimum; larger values pass.
  function automatic seed_t taus_fix(input seed_t v);
    return (v < TAUS_SEED_MIN) ? (v + TAUS_SEED_MIN) : v;
  endfunction

endpackage

// File: rtl/awgn_lcg_step.sv
// One combinational step of the L'Ecuyer LCG, x' = 69069 * x mod 2^32,
// together with the Tausworthe-safe version of that product.
module awgn_lcg_step
  import awgn_pkg::*;
(
  input  logic [SEED_W-1:0] x,
  output logic [SEED_W-1:0] next,
  output logic [SEED_W-1:0] fixed
);

  // A 32x32 product assigned to 32 bits keeps only the low word, which is
  // exactly the mod 2^32 wrap the generator relies on.
  always_comb begin
    next  = x * LCG_MULT;
    fixed = taus_fix(next);
  end

endmodule

// File: rtl/awgn_seed_loader.sv
// Seed loader for the dual-Tausworthe URNG pair: takes one master seed,
// expands it into six component seeds, holds the URNGs in reset while the
// seeds settle, discards a warm-up interval and then flags the outputs valid.
module awgn_seed_loader
  import awgn_pkg::*;
#(
  parameter logic [SEED_W-1:0] DEFAULT_SEED = 32'h1234_5678,
  parameter bit                AUTO_SEED    = 1'b1,
  parameter int                WARMUP       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  output logic [SEED_W-1:0] s0,
  output logic [SEED_W-1:0] s1,
  output logic [SEED_W-1:0] s2,
  output logic [SEED_W-1:0] s3,
  output logic [SEED_W-1:0] s4,
  output logic [SEED_W-1:0] s5,
  output logic              taus_rst,
  output logic              urng_valid,
  output logic              busy
);

  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);
  localparam logic [2:0] IDX_LAST  = 3'(NUM_SEEDS - 1);

  loader_state_t state;
  loader_state_t next_state;

  logic [NUM_SEEDS-1:0][SEED_W-1:0] seed_q;
  seed_t      x;
  seed_t      x0;
  seed_t      lcg_next;
  seed_t      lcg_fixed;
  logic [2:0] idx;
  logic [7:0] warm_cnt;
  logic       auto_pending;
  logic       accept;

  logic taus_rst_d;
  logic urng_valid_d;
  logic busy_d;
  logic seed_ready_d;

  // Single LCG stage, stepped once per EXPAND cycle with x fed back.
  awgn_lcg_step u_lcg (
    .x     (x),
    .next  (lcg_next),
    .fixed (lcg_fixed)
  );

  // Accept logic: the self-seed after reset takes priority over any
  // handshake in that same cycle, and a zero master seed means the default.
  always_comb begin
    accept = auto_pending | (seed_valid & seed_ready);
    x0     = seed_in;
    if (auto_pending || (seed_in == '0)) begin
      x0 = DEFAULT_SEED;
    end
  end

  // State register; reset always lands in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the values the registered outputs take next.
  // taus_rst only drops once WARM has been occupied for a full cycle, so the
  // URNGs see one extra cycle of stable seeds under reset after LOAD.
  // urng_valid likewise trails RUN entry by one cycle but clears at once on
  // a reseed because next_state leaves RUN.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXPAND;
      EXPAND:  if (idx == IDX_LAST) next_state = LOAD;
      LOAD:    next_state = WARM;
      WARM:    if (warm_cnt == WARM_LAST) next_state = RUN;
      RUN:     if (accept) next_state = EXPAND;
      default: next_state = IDLE;
    endcase

    taus_rst_d   = !((state == WARM) || (next_state == RUN));
    urng_valid_d = (state == RUN) && (next_state == RUN);
    busy_d       = (next_state == EXPAND) || (next_state == LOAD) ||
                   (next_state == WARM);
    seed_ready_d = (next_state == IDLE) || (next_state == RUN);
  end

  // The self-seed request lives for exactly the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_pending <= AUTO_SEED;
    end else begin
      auto_pending <= 1'b0;
    end
  end

  // Expansion datapath and warm-up counter. A reset mid-expansion throws
  // away any partially written seeds; a reseed from RUN overwrites the old
  // seeds one per cycle, so untouched entries keep their previous value.
  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      idx      <= '0;
      warm_cnt <= '0;
      seed_q   <= '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            x   <= x0;
            idx <= '0;
          end
        end
        EXPAND: begin
          x           <= lcg_next;
          seed_q[idx] <= lcg_fixed;
          idx         <= idx + 3'd1;
        end
        LOAD: begin
          warm_cnt <= '0;
        end
        WARM: begin
          warm_cnt <= warm_cnt + 8'd1;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      taus_rst   <= 1'b1;
      urng_valid <= 1'b0;
      busy       <= 1'b0;
      seed_ready <= 1'b1;
    end else begin
      taus_rst   <= taus_rst_d;
      urng_valid <= urng_valid_d;
      busy       <= busy_d;
      seed_ready <= seed_ready_d;
    end
  end

  assign s0 = seed_q[0];
  assign s1 = seed_q[1];
  assign s2 = seed_q[2];
  assign s3 = seed_q[3];
  assign s4 = seed_q[4];
  assign s5 = seed_q[5];

endmodule

// File: tb/tb_awgn_seed_loader.sv
// Bench for awgn_seed_loader: a timeline model (cycles since the last
// accepted seed) predicts every output each cycle, and directed tests pin
// the model with hand-computed values.
module tb_awgn_seed_loader;

  localparam int          W     = 16;
  localparam logic [31:0] DEF   = 32'h1234_5678;
  localparam int          W2    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] seed_in;
  logic        seed_valid;

  logic        seed_ready, taus_rst, urng_valid, busy;
  logic [31:0] s0, s1, s2, s3, s4, s5;
  logic [5:0][31:0] dutS;

  logic        a_seed_ready, a_taus_rst, a_urng_valid, a_busy;
  logic [31:0] a0, a1, a2, a3, a4, a5;
  logic [5:0][31:0] autoS;

  int checks = 0;
  int errors = 0;

  logic        rstQ   = 1'b1;
  logic        validQ = 1'b0;
  logic [31:0] seedQ  = '0;

  bit               mIdle    = 1'b1;
  int               mK       = 0;
  bit               expReady = 1'b1;
  logic [5:0][31:0] mOld     = '0;
  logic [5:0][31:0] mNew     = '0;

  awgn_seed_loader #(.DEFAULT_SEED(DEF), .AUTO_SEED(1'b0), .WARMUP(W)) dut (
    .clk(clk), .reset(reset), .seed_in(seed_in), .seed_valid(seed_valid),
    .seed_ready(seed_ready), .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .s5(s5), .taus_rst(taus_rst), .urng_valid(urng_valid), .busy(busy)
  );

  awgn_seed_loader #(.DEFAULT_SEED(DEF), .AUTO_SEED(1'b1), .WARMUP(W2)) dutAuto (
    .clk(clk), .reset(reset), .seed_in(32'd0), .seed_valid(1'b0),
    .seed_ready(a_seed_ready), .s0(a0), .s1(a1), .s2(a2), .s3(a3), .s4(a4),
    .s5(a5), .taus_rst(a_taus_rst), .urng_valid(a_urng_valid), .busy(a_busy)
  );

  assign dutS  = {s5, s4, s3, s2, s1, s0};
  assign autoS = {a5, a4, a3, a2, a1, a0};

  always #5 clk = ~clk;

  // Six seeds straight from the recurrence: zero maps to the default, each
  // product wraps at 2^32, and any result under 16 gets 16 added.
  function automatic logic [5:0][31:0] expandSeed(input logic [31:0] seed);
    longint unsigned x;
    logic [5:0][31:0] r;
    x = (seed == 32'd0) ? 64'(DEF) : 64'(seed);
    for (int i = 0; i < 6; i++) begin
      x = (x * 64'd69069) % 64'h1_0000_0000;
      r[i] = (x < 64'd16) ? 32'(x + 64'd16) : 32'(x);
    end
    return r;
  endfunction

  // Inverse of 69069 mod 2^32 by Newton iteration (bits double per step).
  function automatic logic [31:0] lcgInverse();
    logic [31:0] a;
    logic [31:0] inv;
    a   = 32'd69069;
    inv = a;
    for (int i = 0; i < 5; i++) inv = inv * (32'd2 - a * inv);
    return inv;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0d (0x%08h) want %0d (0x%08h) at %0t",
               name, got, got, want, want, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] seed);
    seed_in    = seed;
    seed_valid = 1'b1;
    step();
    seed_valid = 1'b0;
  endtask

  task automatic waitUrng(input int limit, output int n);
    n = 0;
    while (!urng_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic waitTausLow(input int limit, output int n);
    n = 0;
    while (taus_rst && n < limit) begin
      step();
      n++;
    end
  endtask

  // Latch what the DUT saw at each rising edge for the model.
  always @(posedge clk) begin
    rstQ   <= reset;
    validQ <= seed_valid;
    seedQ  <= seed_in;
  end

  // Model advance and full output comparison, once per cycle.
  initial begin
    logic [31:0] expS;
    forever begin
      @(negedge clk);
      if (rstQ) begin
        mIdle = 1'b1;
        mK    = 0;
        mOld  = '0;
        mNew  = '0;
      end else if (validQ && expReady) begin
        mOld  = mNew;
        mNew  = expandSeed(seedQ);
        mIdle = 1'b0;
        mK    = 0;
      end else if (!mIdle && mK < 100000) begin
        mK++;
      end
      expReady = mIdle || (mK >= 7 + W);

      checkOutput("seed_ready", 32'(seed_ready), 32'(expReady));
      checkOutput("taus_rst",   32'(taus_rst),   32'(mIdle || mK <= 7));
      checkOutput("urng_valid", 32'(urng_valid), 32'(!mIdle && mK >= 8 + W));
      checkOutput("busy",       32'(busy),       32'(!mIdle && mK <= 6 + W));
      for (int i = 0; i < 6; i++) begin
        expS = (!mIdle && mK < i + 1) ? mOld[i] : mNew[i];
        checkOutput($sformatf("s%0d", i), dutS[i], expS);
      end
    end
  end

  initial begin
    int n;
    int acc;
    logic [31:0] fixSeed;
    logic [5:0][31:0] ref6;

    reset      = 1'b1;
    seed_valid = 1'b0;
    seed_in    = '0;
    repeat (3) step();

    $display("[TB] reset values");
    checkOutput("rst_s0", s0, 32'd0);
    checkOutput("rst_s5", s5, 32'd0);
    checkOutput("rst_taus", 32'(taus_rst), 32'd1);
    checkOutput("rst_ready", 32'(seed_ready), 32'd1);
    checkOutput("rst_urng", 32'(urng_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("auto_rst_ready", 32'(a_seed_ready), 32'd1);

    // Model pins against hand-computed values.
    ref6 = expandSeed(32'd1);
    checkOutput("model_s0_seed1", ref6[0], 32'd69069);
    checkOutput("model_s1_seed1", ref6[1], 32'd475559465);
    ref6 = expandSeed(32'd2);
    checkOutput("model_s0_seed2", ref6[0], 32'd138138);
    fixSeed = lcgInverse() * 32'd5;
    ref6 = expandSeed(fixSeed);
    checkOutput("model_fix_s0", ref6[0], 32'd21);

    // Release reset: the auto-seeding instance starts on the very next edge.
    reset = 1'b0;
    ref6  = expandSeed(32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) checkOutput("auto_ready_k0", 32'(a_seed_ready), 32'd0);
      if (k == 0) checkOutput("auto_busy_k0", 32'(a_busy), 32'd1);
      if (k == 6) begin
        for (int i = 0; i < 6; i++)
          checkOutput($sformatf("auto_s%0d", i), autoS[i], ref6[i]);
      end
      if (k == 7) checkOutput("auto_taus_k7", 32'(a_taus_rst), 32'd1);
      if (k == 8) checkOutput("auto_taus_k8", 32'(a_taus_rst), 32'd0);
      if (k == 8) checkOutput("auto_urng_k8", 32'(a_urng_valid), 32'd0);
      if (k == 9) checkOutput("auto_urng_k9", 32'(a_urng_valid), 32'd1);
    end

    $display("[TB] test 1: seed 1");
    applyStimulus(32'd1);
    waitTausLow(40, n);
    checkOutput("t1_taus_delay", 32'(n), 32'd8);
    waitUrng(40, n);
    checkOutput("t1_urng_delay", 32'(n), 32'(W));
    checkOutput("t1_s0", s0, 32'd69069);
    checkOutput("t1_s1", s1, 32'd475559465);

    $display("[TB] test 2: seed 0 uses default");
    applyStimulus(32'd0);
    waitUrng(80, n);
    checkOutput("t2_urng_delay", 32'(n), 32'(8 + W));
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t2_min_s%0d", i), 32'(dutS[i] >= 32'd16), 32'd1);

    $display("[TB] test 3: fix path");
    applyStimulus(fixSeed);
    waitUrng(80, n);
    checkOutput("t3_s0", s0, 32'd21);
    checkOutput("t3_s1", s1, 32'd345345);

    $display("[TB] test 4: reseed in RUN");
    applyStimulus(32'd2);
    checkOutput("t4_urng_drop", 32'(urng_valid), 32'd0);
    checkOutput("t4_taus_rise", 32'(taus_rst), 32'd1);
    waitTausLow(40, n);
    checkOutput("t4_taus_delay", 32'(n), 32'd8);
    waitUrng(40, n);
    checkOutput("t4_urng_delay", 32'(n), 32'(W));
    checkOutput("t4_s0", s0, 32'd138138);

    $display("[TB] test 5: reset mid-expansion");
    applyStimulus(32'd7);
    repeat (3) step();
    checkOutput("t5_s0_before", s0, 32'd483483);
    reset = 1'b1;
    step();
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t5_s%0d", i), dutS[i], 32'd0);
    checkOutput("t5_taus", 32'(taus_rst), 32'd1);
    checkOutput("t5_ready", 32'(seed_ready), 32'd1);
    checkOutput("t5_urng", 32'(urng_valid), 32'd0);
    reset = 1'b0;
    step();

    $display("[TB] test 6: seed_valid held high");
    seed_in    = 32'd3;
    seed_valid = 1'b1;
    acc = 0;
    for (int j = 0; j < 3 * (8 + W); j++) begin
      if (seed_ready) acc++;
      step();
    end
    seed_valid = 1'b0;
    checkOutput("t6_accepts", 32'(acc), 32'd3);
    waitUrng(80, n);
    checkOutput("t6_final_urng", 32'(urng_valid), 32'd1);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
